// File: rtl/sa_pkg.sv
// Shared defaults, tile FSM state encoding and a constant-width helper
// for the systolic-array output drain.
package sa_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } tile_state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sa_output_drain_if.sv
// Array-side column inputs plus the downstream row handshake and status
// flags of the output drain, bundled as one port.
interface sa_output_drain_if
    import sa_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
) ();

    logic            start;
    logic [N-1:0]    col_valid;
    logic [N*DW-1:0] col_data;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_data;
    logic            out_last;
    logic            busy;
    logic            tile_done;
    logic            overflow;
    logic            skew_err;

    modport slave (
        input  start, col_valid, col_data, out_ready,
        output out_valid, out_data, out_last, busy, tile_done, overflow, skew_err
    );

    modport master (
        output start, col_valid, col_data, out_ready,
        input  out_valid, out_data, out_last, busy, tile_done, overflow, skew_err
    );

endinterface

// File: rtl/sa_row_fifo.sv
// Row buffer: power-of-2 depth, extra pointer MSB distinguishes full from
// empty. The caller never pushes into a full FIFO without a same-cycle pop.
module sa_row_fifo
    import sa_pkg::*;
#(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Storage is not cleared, so the head is masked while empty to keep out_data at 0.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the memory array is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sa_output_drain.sv
// Bottom-edge drain of the systolic array: de-skews columns into rows,
// buffers them, and closes a tile after ROWS rows with a down-counter.
module sa_output_drain
    import sa_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DW         = DEF_DW,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    sa_output_drain_if.slave   bus
);

    localparam int RW = clog2(ROWS + 1);

    logic [N-1:0]    al_valid;
    logic [N*DW-1:0] al_data;

    // Column j is delayed N-1-j cycles so all columns of a row line up with column N-1.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_comb
            assign al_valid[j]          = bus.col_valid[j];
            assign al_data[j*DW +: DW]  = bus.col_data[j*DW +: DW];
        end else begin : g_dly
            logic [D-1:0]  v_q, v_d;
            logic [DW-1:0] d_q [D];
            logic [DW-1:0] d_d [D];

            always_comb begin
                v_d[0] = bus.col_valid[j];
                d_d[0] = bus.col_data[j*DW +: DW];
                for (int k = 1; k < D; k++) begin
                    v_d[k] = v_q[k-1];
                    d_d[k] = d_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_q <= '0;
                    for (int k = 0; k < D; k++) d_q[k] <= '0;
                end else begin
                    v_q <= v_d;
                    for (int k = 0; k < D; k++) d_q[k] <= d_d[k];
                end
            end

            assign al_valid[j]         = v_q[D-1];
            assign al_data[j*DW +: DW] = d_q[D-1];
        end
    end

    logic row_valid, row_skew;
    assign row_valid = |al_valid;
    assign row_skew  = row_valid && !(&al_valid);

    tile_state_e   state_q, state_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          last_drop_q, last_drop_d;
    logic          overflow_q, overflow_d;
    logic          skew_err_q, skew_err_d;

    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic          head_last, collect_row, is_last, tile_done;
    logic [N*DW:0] fifo_rdata;

    assign collect_row = (state_q == COLLECT) && row_valid;
    assign fifo_pop    = !fifo_empty && bus.out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign fifo_push   = collect_row && (!fifo_full || fifo_pop);
    assign is_last     = (rem_q == RW'(1));

    sa_row_fifo #(
        .W     (N*DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({is_last, al_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_last = fifo_rdata[N*DW];

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        last_drop_d = last_drop_q;
        overflow_d  = overflow_q;
        skew_err_d  = skew_err_q;
        tile_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = COLLECT;
                    rem_d       = RW'(ROWS);
                    last_drop_d = 1'b0;
                end
            end
            COLLECT: begin
                if (collect_row) begin
                    rem_d = rem_q - RW'(1);
                    if (!fifo_push) overflow_d = 1'b1;
                    if (row_skew)   skew_err_d = 1'b1;
                    if (is_last) begin
                        state_d     = FLUSH;
                        last_drop_d = !fifo_push;
                    end
                end
            end
            FLUSH: begin
                // A dropped last row never reaches the head, so the tile closes once the FIFO drains.
                if ((fifo_pop && head_last) || (last_drop_q && fifo_empty)) begin
                    tile_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            last_drop_q <= 1'b0;
            overflow_q  <= 1'b0;
            skew_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            last_drop_q <= last_drop_d;
            overflow_q  <= overflow_d;
            skew_err_q  <= skew_err_d;
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_rdata[N*DW-1:0];
    assign bus.out_last  = !fifo_empty && head_last;
    assign bus.busy      = (state_q != IDLE);
    assign bus.tile_done = tile_done;
    assign bus.overflow  = overflow_q;
    assign bus.skew_err  = skew_err_q;

endmodule
